// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

  // Controller operating state: normal run, draining toward an ebreak, halted.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // Bit positions of each inter-stage register in the valid/ena vectors.
  localparam int STG_IFID  = 0;
  localparam int STG_IDEX  = 1;
  localparam int STG_EXMEM = 2;
  localparam int STG_MEMWB = 3;
  localparam int NUM_STG   = 4;

  localparam int CNT_W_DEFAULT = 32;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard comparator: ID source registers against the EX load destination.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the result is consumed by the stall controller.
// Ports: id_rs1/id_rs2 + id_use_rs1/id_use_rs2 (ID operands), ex_load/ex_rf_waddr (EX load), load_use (out).
module hazard_detect (
  input  logic       ex_load,
  input  logic [4:0] ex_rf_waddr,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit  = id_use_rs1 && (id_rs1 == ex_rf_waddr);
    rs2_hit  = id_use_rs2 && (id_rs2 == ex_rf_waddr);
    // x0 is hardwired to zero, so a load targeting it can never feed a consumer.
    load_use = ex_load && (ex_rf_waddr != 5'd0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: drives valid/ena of IF/ID, ID/EX, EX/MEM, MEM/WB and PC enable.
// Latency: controls are combinational from inputs+state; state and counters update on posedge clk.
// Backpressure: mem_busy freezes the whole pipe; if_busy and load-use stall the front end only.
// Ports: clk/rst; ID/EX hazard inputs; ex_redirect, ex_sys, wb_sys, if_busy, mem_busy;
//        pc_ena, <stage>_valid/<stage>_ena, halt, cyc_cnt/stall_cnt (saturating).
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_load,
  input  logic [4:0]       ex_rf_waddr,
  input  logic             ex_redirect,
  input  logic             ex_sys,
  input  logic             wb_sys,
  input  logic             if_busy,
  input  logic             mem_busy,
  output logic             pc_ena,
  output logic             ifid_valid,
  output logic             idex_valid,
  output logic             exmem_valid,
  output logic             memwb_valid,
  output logic             ifid_ena,
  output logic             idex_ena,
  output logic             exmem_ena,
  output logic             memwb_ena,
  output logic             halt,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [NUM_STG-1:0] valid_v;
  logic [NUM_STG-1:0] ena_v;
  logic               stall_ev;
  logic               load_use;

  hazard_detect u_hazard (
    .ex_load     (ex_load),
    .ex_rf_waddr (ex_rf_waddr),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .load_use    (load_use)
  );

  always_comb begin
    state_d  = state_q;
    valid_v  = '1;
    ena_v    = '1;
    pc_ena   = 1'b1;
    halt     = 1'b0;
    stall_ev = 1'b0;

    if (rst) begin
      valid_v = '0;
      ena_v   = '0;
      pc_ena  = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          // An ebreak retiring in WB halts next edge; this cycle still follows the rule chain.
          if (wb_sys) state_d = ST_HALT;
          if (mem_busy) begin
            // Full freeze: a pending redirect or ebreak in EX is held and acted on later.
            ena_v    = '0;
            pc_ena   = 1'b0;
            stall_ev = 1'b1;
          end else if (ex_sys) begin
            pc_ena            = 1'b0;
            valid_v[STG_IFID] = 1'b0;
            valid_v[STG_IDEX] = 1'b0;
            if (!wb_sys) state_d = ST_DRAIN;
          end else if (ex_redirect) begin
            // Redirect squashes the front; any load-use against a wrong-path instr is moot.
            valid_v[STG_IFID] = 1'b0;
            valid_v[STG_IDEX] = 1'b0;
          end else if (load_use) begin
            pc_ena            = 1'b0;
            ena_v[STG_IFID]   = 1'b0;
            valid_v[STG_IDEX] = 1'b0;
            stall_ev          = 1'b1;
          end else if (if_busy) begin
            pc_ena            = 1'b0;
            valid_v[STG_IFID] = 1'b0;
            stall_ev          = 1'b1;
          end
        end
        ST_DRAIN: begin
          pc_ena            = 1'b0;
          valid_v[STG_IFID] = 1'b0;
          valid_v[STG_IDEX] = 1'b0;
          if (mem_busy) begin
            ena_v[STG_EXMEM] = 1'b0;
            ena_v[STG_MEMWB] = 1'b0;
            stall_ev         = 1'b1;
          end
          if (wb_sys) state_d = ST_HALT;
        end
        ST_HALT: begin
          ena_v  = '0;
          pc_ena = 1'b0;
          halt   = 1'b1;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    ifid_valid  = valid_v[STG_IFID];
    idex_valid  = valid_v[STG_IDEX];
    exmem_valid = valid_v[STG_EXMEM];
    memwb_valid = valid_v[STG_MEMWB];
    ifid_ena    = ena_v[STG_IFID];
    idex_ena    = ena_v[STG_IDEX];
    exmem_ena   = ena_v[STG_EXMEM];
    memwb_ena   = ena_v[STG_MEMWB];
  end

  // Saturating performance counters; cycle count stops once halted.
  always_comb begin
    cyc_d   = cyc_q;
    stall_d = stall_q;
    if ((state_q != ST_HALT) && (cyc_q != '1)) cyc_d = cyc_q + CNT_W'(1);
    if (stall_ev && (stall_q != '1))           stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cyc_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stall_q <= stall_d;
    end
  end

  assign cyc_cnt   = cyc_q;
  assign stall_cnt = stall_q;

endmodule
